// File: rtl/loop_filter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// loop_filter
//
// Proportional-integral loop filter between the phase-frequency detector and
// the DCO. Accepted error samples are integrated (with clamping and
// anti-windup), then combined with a proportional term around a centre control
// word. The result is saturated into an unsigned control word. A hysteretic
// lock detector counts runs of zero and nonzero error samples.
//
// Pipeline: stage 1 captures the sample and updates the integrator and the lock
// state. Stage 2 forms the control word one cycle later from the updated
// integrator.
//
// Ports:
//   sys_clk     in   system clock
//   rst         in   asynchronous active-high reset
//   error_in    in   signed phase error from the detector (ERR_W bits)
//   sample_en   in   qualifies error_in this cycle
//   freeze      in   holds all filter state while high
//   ctrl_out    out  DCO control word (CTRL_W bits)
//   ctrl_valid  out  one-cycle pulse when ctrl_out is updated
//   locked      out  lock indication
//   sat_hi      out  ctrl_out clamped at its maximum
//   sat_lo      out  ctrl_out clamped at zero
// -----------------------------------------------------------------------------
module loop_filter #(
    parameter int                ERR_W         = 4,
    parameter int                ACC_W         = 24,
    parameter int                CTRL_W        = 16,
    parameter logic [CTRL_W-1:0] CTRL_INIT     = 'h8000,
    parameter int                KP_SHIFT      = 2,
    parameter int                KI_SHIFT      = 6,
    parameter int                LOCK_CYCLES   = 1024,
    parameter int                UNLOCK_CYCLES = 64
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] error_in,
    input  logic                    sample_en,
    input  logic                    freeze,
    output logic [CTRL_W-1:0]       ctrl_out,
    output logic                    ctrl_valid,
    output logic                    locked,
    output logic                    sat_hi,
    output logic                    sat_lo
);

    localparam int SUM_W = ACC_W + 2;
    localparam int Z_W   = $clog2(LOCK_CYCLES + 1);
    localparam int N_W   = $clog2(UNLOCK_CYCLES + 1);

    // Symmetric integrator limits +/-(2^(ACC_W-1)-1), one bit wider than the
    // integrator so the unclamped sum can be compared against them.
    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

    localparam logic [Z_W-1:0] Z_LIMIT = Z_W'(LOCK_CYCLES);
    localparam logic [N_W-1:0] N_LIMIT = N_W'(UNLOCK_CYCLES);

    // Registered state
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ERR_W-1:0] r_err;
    logic                    r_v1;
    logic [Z_W-1:0]          r_zcnt;
    logic [N_W-1:0]          r_ncnt;
    logic                    r_locked;
    logic [CTRL_W-1:0]       r_ctrl;
    logic                    r_ctrl_valid;
    logic                    r_sat_hi;
    logic                    r_sat_lo;

    // Stage 1 combinational terms
    logic                    w_accept;
    logic                    w_err_zero;
    logic                    w_err_pos;
    logic                    w_err_neg;
    logic                    w_hold_int;
    logic signed [ACC_W:0]   w_acc_sum;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [Z_W-1:0]          w_z_inc;
    logic [N_W-1:0]          w_n_inc;

    // Stage 2 combinational terms
    logic signed [SUM_W-1:0] w_acc_wide;
    logic signed [SUM_W-1:0] w_i_term;
    logic signed [SUM_W-1:0] w_p_term;
    logic signed [SUM_W-1:0] w_init_term;
    logic signed [SUM_W-1:0] w_sum;
    logic                    w_sum_neg;
    logic                    w_sum_over;

    assign w_accept   = sample_en & ~freeze;
    assign w_err_zero = ~|error_in;
    assign w_err_neg  = error_in[ERR_W-1];
    assign w_err_pos  = ~w_err_neg & ~w_err_zero;

    // Anti-windup looks at the flags registered before this edge, so a sample
    // still in flight may integrate once more before the clamp takes effect.
    assign w_hold_int = (r_sat_hi & w_err_pos) | (r_sat_lo & w_err_neg);

    assign w_acc_sum = {r_acc[ACC_W-1], r_acc}
                     + {{(ACC_W+1-ERR_W){error_in[ERR_W-1]}}, error_in};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_acc_next = r_acc;
        if (!w_hold_int) begin
            if (w_acc_sum > ACC_MAX)
                w_acc_next = ACC_MAX[ACC_W-1:0];
            else if (w_acc_sum < ACC_MIN)
                w_acc_next = ACC_MIN[ACC_W-1:0];
            else
                w_acc_next = w_acc_sum[ACC_W-1:0];
        end
    end

    assign w_z_inc = (r_zcnt == Z_LIMIT) ? r_zcnt : r_zcnt + Z_W'(1);
    assign w_n_inc = (r_ncnt == N_LIMIT) ? r_ncnt : r_ncnt + N_W'(1);

    // Control word = centre + I/2^KI + err*2^KP, evaluated wide enough that
    // neither term can overflow before the range check.
    assign w_acc_wide  = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_i_term    = w_acc_wide >>> KI_SHIFT;
    assign w_p_term    = {{(SUM_W-ERR_W){r_err[ERR_W-1]}}, r_err} <<< KP_SHIFT;
    assign w_init_term = {{(SUM_W-CTRL_W){1'b0}}, CTRL_INIT};
    assign w_sum       = w_init_term + w_i_term + w_p_term;

    assign w_sum_neg  = w_sum[SUM_W-1];
    assign w_sum_over = ~w_sum_neg & (|w_sum[SUM_W-2:CTRL_W]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_acc        <= '0;
            r_err        <= '0;
            r_v1         <= 1'b0;
            r_zcnt       <= '0;
            r_ncnt       <= '0;
            r_locked     <= 1'b0;
            r_ctrl       <= CTRL_INIT;
            r_ctrl_valid <= 1'b0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
        end else begin
            // Stage 2 drains regardless of freeze; freeze only blocks new
            // samples, so ctrl_valid falls once the pipeline is empty.
            r_ctrl_valid <= r_v1;
            if (r_v1) begin
                if (w_sum_neg) begin
                    r_ctrl   <= '0;
                    r_sat_lo <= 1'b1;
                    r_sat_hi <= 1'b0;
                end else if (w_sum_over) begin
                    r_ctrl   <= '1;
                    r_sat_lo <= 1'b0;
                    r_sat_hi <= 1'b1;
                end else begin
                    r_ctrl   <= w_sum[CTRL_W-1:0];
                    r_sat_lo <= 1'b0;
                    r_sat_hi <= 1'b0;
                end
            end

            // Stage 1 and the lock detector advance only on accepted samples.
            r_v1 <= w_accept;
            if (w_accept) begin
                r_acc <= w_acc_next;
                r_err <= error_in;
                if (w_err_zero) begin
                    r_zcnt <= w_z_inc;
                    r_ncnt <= '0;
                    if (w_z_inc == Z_LIMIT)
                        r_locked <= 1'b1;
                end else begin
                    r_zcnt <= '0;
                    r_ncnt <= w_n_inc;
                    if (w_n_inc == N_LIMIT)
                        r_locked <= 1'b0;
                end
            end
        end
    end

    assign ctrl_out   = r_ctrl;
    assign ctrl_valid = r_ctrl_valid;
    assign locked     = r_locked;
    assign sat_hi     = r_sat_hi;
    assign sat_lo     = r_sat_lo;

endmodule

// File: tb/tb_loop_filter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_loop_filter
//
// Drives two loop_filter instances from the same stimulus: u_dut with the
// default parameters, and u_small with a narrow control word so saturation is
// reachable in a short run. Each is compared against an integer-arithmetic
// reference model of the filter's rules.
// -----------------------------------------------------------------------------
module tb_loop_filter;

    typedef struct packed {
        int acc;
        int err;
        int v1;
        int ctrl;
        int valid;
        int sat_hi;
        int sat_lo;
        int z;
        int n;
        int locked;
    } m_state_t;

    typedef struct packed {
        int init;
        int ki;
        int kp;
        int ctrl_max;
        int acc_max;
        int lock_n;
        int unlock_n;
    } m_cfg_t;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic signed [3:0] error_in;
    logic              sample_en;
    logic              freeze;

    logic [15:0] ctrl_out;
    logic        ctrl_valid, locked, sat_hi, sat_lo;
    logic [7:0]  s_ctrl_out;
    logic        s_ctrl_valid, s_locked, s_sat_hi, s_sat_lo;

    int n_total = 0;
    int n_bad   = 0;

    m_cfg_t   cfg_m, cfg_s;
    m_state_t mm, ms;

    always #5 sys_clk = ~sys_clk;

    loop_filter u_dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .error_in   (error_in),
        .sample_en  (sample_en),
        .freeze     (freeze),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .locked     (locked),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo)
    );

    loop_filter #(
        .ERR_W         (4),
        .ACC_W         (12),
        .CTRL_W        (8),
        .CTRL_INIT     (8'h80),
        .KP_SHIFT      (2),
        .KI_SHIFT      (1),
        .LOCK_CYCLES   (16),
        .UNLOCK_CYCLES (4)
    ) u_small (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .error_in   (error_in),
        .sample_en  (sample_en),
        .freeze     (freeze),
        .ctrl_out   (s_ctrl_out),
        .ctrl_valid (s_ctrl_valid),
        .locked     (s_locked),
        .sat_hi     (s_sat_hi),
        .sat_lo     (s_sat_lo)
    );

    // ---------------- reference model ----------------
    function automatic m_state_t model_reset(input m_cfg_t c);
        m_state_t s;
        s        = '0;
        s.ctrl   = c.init;
        return s;
    endfunction

    // One rising edge of the filter, written from the rules: the output stage
    // consumes the previously captured sample, then the new sample (if
    // accepted) is integrated using the flags as they were before the edge.
    task automatic model_step(input m_state_t s, input bit en, input bit frz,
                              input int e, input m_cfg_t c, output m_state_t nx);
        int sum;
        int ni;
        nx       = s;
        nx.valid = s.v1;
        if (s.v1 != 0) begin
            sum = c.init + (s.acc >>> c.ki) + s.err * (1 << c.kp);
            if (sum < 0) begin
                nx.ctrl = 0;          nx.sat_lo = 1; nx.sat_hi = 0;
            end else if (sum > c.ctrl_max) begin
                nx.ctrl = c.ctrl_max; nx.sat_lo = 0; nx.sat_hi = 1;
            end else begin
                nx.ctrl = sum;        nx.sat_lo = 0; nx.sat_hi = 0;
            end
        end
        if (en && !frz) begin
            if (!((s.sat_hi != 0 && e > 0) || (s.sat_lo != 0 && e < 0))) begin
                ni = s.acc + e;
                if (ni > c.acc_max)  ni = c.acc_max;
                if (ni < -c.acc_max) ni = -c.acc_max;
                nx.acc = ni;
            end
            nx.err = e;
            nx.v1  = 1;
            if (e == 0) begin
                nx.n = 0;
                nx.z = (s.z < c.lock_n) ? s.z + 1 : s.z;
                if (nx.z == c.lock_n) nx.locked = 1;
            end else begin
                nx.z = 0;
                nx.n = (s.n < c.unlock_n) ? s.n + 1 : s.n;
                if (nx.n == c.unlock_n) nx.locked = 0;
            end
        end else begin
            nx.v1 = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit en, input bit frz, input int e);
        m_state_t nx;
        sample_en = en;
        freeze    = frz;
        error_in  = 4'(e);
        @(posedge sys_clk);
        model_step(mm, en, frz, e, cfg_m, nx); mm = nx;
        model_step(ms, en, frz, e, cfg_s, nx); ms = nx;
        #1;
    endtask

    task automatic do_reset();
        sample_en = 1'b0;
        freeze    = 1'b0;
        error_in  = '0;
        rst       = 1'b1;
        #2;
        rst       = 1'b0;
        mm        = model_reset(cfg_m);
        ms        = model_reset(cfg_s);
    endtask

    function automatic int rand_err();
        return int'($urandom_range(0, 15)) - 8;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_total++;
        if (ctrl_out !== 16'h8000 || ctrl_valid !== 1'b0 || locked !== 1'b0 ||
            sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_init: ctrl=%h valid=%b locked=%b hi=%b lo=%b, want 8000 0 0 0 0",
                     ctrl_out, ctrl_valid, locked, sat_hi, sat_lo);
        end
        // Load some state, then reset between clock edges.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, (i % 3) - 1 + 4);
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (ctrl_out !== 16'h8000 || ctrl_valid !== 1'b0 || locked !== 1'b0 ||
            sat_hi !== 1'b0 || sat_lo !== 1'b0 || s_ctrl_out !== 8'h80) begin
            n_bad++;
            $display("FAIL reset_async: ctrl=%h valid=%b locked=%b hi=%b lo=%b small=%h, want 8000 0 0 0 0 80",
                     ctrl_out, ctrl_valid, locked, sat_hi, sat_lo, s_ctrl_out);
        end
        #1 rst = 1'b0;
        mm = model_reset(cfg_m);
        ms = model_reset(cfg_s);
    endtask

    task automatic test_single_step();
        do_reset();
        tick(1'b1, 1'b0, 1);
        n_total++;
        if (ctrl_valid !== 1'b0 || ctrl_out !== 16'h8000) begin
            n_bad++;
            $display("FAIL step_latency: ctrl=%h valid=%b one cycle after sample, want 8000 0",
                     ctrl_out, ctrl_valid);
        end
        tick(1'b1, 1'b0, 0);
        n_total++;
        if (ctrl_valid !== 1'b1 || ctrl_out !== 16'h8004) begin
            n_bad++;
            $display("FAIL step_plus1: ctrl=%h valid=%b, want 8004 1", ctrl_out, ctrl_valid);
        end
        tick(1'b1, 1'b0, 0);
        n_total++;
        if (ctrl_valid !== 1'b1 || ctrl_out !== 16'h8000) begin
            n_bad++;
            $display("FAIL step_zero: ctrl=%h valid=%b, want 8000 1", ctrl_out, ctrl_valid);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int i = 0; i < 64; i++) tick(1'b1, 1'b0, 1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (ctrl_out !== 16'h8005 || ctrl_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_up: ctrl=%h valid=%b, want 8005 1", ctrl_out, ctrl_valid);
        end
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (ctrl_out !== 16'h8005 || ctrl_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_hold: ctrl=%h valid=%b, want 8005 0", ctrl_out, ctrl_valid);
        end
        do_reset();
        for (int i = 0; i < 128; i++) tick(1'b1, 1'b0, -1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (ctrl_out !== 16'h7FFA) begin
            n_bad++;
            $display("FAIL ramp_down: ctrl=%h, want 7ffa", ctrl_out);
        end
    endtask

    task automatic test_saturation();
        int budget;
        // Low side on the narrow instance.
        do_reset();
        budget = 0;
        while (s_sat_lo !== 1'b1 && budget < 1000) begin
            tick(1'b1, 1'b0, -1);
            budget++;
        end
        n_total++;
        if (s_sat_lo !== 1'b1 || s_ctrl_out !== 8'h00) begin
            n_bad++;
            $display("FAIL sat_lo_reach: lo=%b ctrl=%h after %0d samples, want 1 00",
                     s_sat_lo, s_ctrl_out, budget);
        end
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, -1);
        n_total++;
        if (s_sat_lo !== 1'b1 || s_ctrl_out !== 8'h00) begin
            n_bad++;
            $display("FAIL sat_lo_hold: lo=%b ctrl=%h, want 1 00", s_sat_lo, s_ctrl_out);
        end
        tick(1'b1, 1'b0, 1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (s_ctrl_out !== 8'(ms.ctrl) || s_ctrl_out == 8'h00 || s_sat_lo !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_lo_recover: ctrl=%h lo=%b, want %h 0 (nonzero)",
                     s_ctrl_out, s_sat_lo, 8'(ms.ctrl));
        end
        // High side.
        do_reset();
        budget = 0;
        while (s_sat_hi !== 1'b1 && budget < 1000) begin
            tick(1'b1, 1'b0, 1);
            budget++;
        end
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0, 1);
        n_total++;
        if (s_sat_hi !== 1'b1 || s_ctrl_out !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat_hi_hold: hi=%b ctrl=%h, want 1 ff", s_sat_hi, s_ctrl_out);
        end
        tick(1'b1, 1'b0, -1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (s_ctrl_out !== 8'(ms.ctrl) || s_ctrl_out == 8'hFF || s_sat_hi !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_hi_recover: ctrl=%h hi=%b, want %h 0", s_ctrl_out, s_sat_hi,
                     8'(ms.ctrl));
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 1023; i++) tick(1'b1, 1'b0, 0);
        n_total++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_1023: locked=%b, want 0", locked);
        end
        tick(1'b1, 1'b0, 0);
        n_total++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_1024: locked=%b, want 1", locked);
        end
        for (int i = 0; i < 63; i++) tick(1'b1, 1'b0, 1);
        n_total++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL unlock_63: locked=%b, want 1", locked);
        end
        tick(1'b1, 1'b0, 1);
        n_total++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL unlock_64: locked=%b, want 0", locked);
        end
        for (int i = 0; i < 1024; i++) tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, -1);
        tick(1'b1, 1'b0, 0);
        for (int i = 0; i < 63; i++) tick(1'b1, 1'b0, -1);
        n_total++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL unlock_interleave: locked=%b, want 1", locked);
        end
        tick(1'b1, 1'b0, -1);
        n_total++;
        if (locked !== 1'b0) begin
            n_bad++;
            $display("FAIL unlock_after_interleave: locked=%b, want 0", locked);
        end
    endtask

    task automatic test_freeze();
        logic [15:0] c0;
        logic        l0;
        do_reset();
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b0, 1);
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);
        c0 = ctrl_out;
        l0 = locked;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1);
            n_total++;
            if (ctrl_out !== c0 || ctrl_valid !== 1'b0 || locked !== l0) begin
                n_bad++;
                $display("FAIL freeze_hold[%0d]: ctrl=%h valid=%b locked=%b, want %h 0 %b",
                         i, ctrl_out, ctrl_valid, locked, c0, l0);
            end
        end
        // I should be 60 here; one more sample gives 61 -> still 0x8004.
        tick(1'b1, 1'b0, 1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (ctrl_out !== 16'h8004 || ctrl_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL freeze_resume: ctrl=%h valid=%b, want 8004 1", ctrl_out, ctrl_valid);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1);
        tick(1'b0, 1'b0, 0);
        n_total++;
        if (ctrl_out !== 16'h8005) begin
            n_bad++;
            $display("FAIL freeze_resume_64: ctrl=%h, want 8005", ctrl_out);
        end
    endtask

    task automatic test_back_to_back();
        bit en, frz;
        int e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) do_reset();
            en  = ($urandom_range(0, 9) != 0);
            frz = ($urandom_range(0, 15) == 0);
            if ((i / 300) % 2 == 1)
                e = ($urandom_range(0, 19) == 0) ? rand_err() : 0;
            else
                e = ($urandom_range(0, 1) == 0) ? 0 : rand_err();
            tick(en, frz, e);
            n_total++;
            if (ctrl_out !== 16'(mm.ctrl) || ctrl_valid !== 1'(mm.valid) ||
                locked !== 1'(mm.locked) || sat_hi !== 1'(mm.sat_hi) ||
                sat_lo !== 1'(mm.sat_lo)) begin
                n_bad++;
                $display("FAIL b2b_main[%0d]: got ctrl=%h v=%b l=%b hi=%b lo=%b, want %h %0d %0d %0d %0d",
                         i, ctrl_out, ctrl_valid, locked, sat_hi, sat_lo,
                         16'(mm.ctrl), mm.valid, mm.locked, mm.sat_hi, mm.sat_lo);
            end
            n_total++;
            if (s_ctrl_out !== 8'(ms.ctrl) || s_ctrl_valid !== 1'(ms.valid) ||
                s_locked !== 1'(ms.locked) || s_sat_hi !== 1'(ms.sat_hi) ||
                s_sat_lo !== 1'(ms.sat_lo)) begin
                n_bad++;
                $display("FAIL b2b_small[%0d]: got ctrl=%h v=%b l=%b hi=%b lo=%b, want %h %0d %0d %0d %0d",
                         i, s_ctrl_out, s_ctrl_valid, s_locked, s_sat_hi, s_sat_lo,
                         8'(ms.ctrl), ms.valid, ms.locked, ms.sat_hi, ms.sat_lo);
            end
        end
    endtask

    initial begin
        cfg_m = '{init: 32'h8000, ki: 6, kp: 2, ctrl_max: 65535,
                  acc_max: (1 << 23) - 1, lock_n: 1024, unlock_n: 64};
        cfg_s = '{init: 32'h80, ki: 1, kp: 2, ctrl_max: 255,
                  acc_max: (1 << 11) - 1, lock_n: 16, unlock_n: 4};
        mm = model_reset(cfg_m);
        ms = model_reset(cfg_s);

        test_reset();
        test_single_step();
        test_ramp();
        test_saturation();
        test_lock();
        test_freeze();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d",
                 n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
